// File: rtl/interval_timer_mc_pkg.sv
// rtl/interval_timer_mc_pkg.sv - register map and field positions shared by the interval timer files
// Package timer_mc_pkg: register offsets, control/status bit positions,
// PRESCALE field placement and a channel-index width helper.
package timer_mc_pkg;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_CONTROL = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_SNAP    = 2'd3;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;
    localparam int ST_TO     = 0;
    localparam int ST_RUN    = 1;

    localparam int PRE_LSB = 8;
    localparam int PRE_W   = 8;

    // Width of the channel-index field; at least one bit so a
    // single-channel build still has a legal vector to compare against.
    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/interval_timer_mc_if.sv
// rtl/interval_timer_mc_if.sv - Avalon-MM slave bus bundle for interval_timer_mc
// Signals: address {channel, reg}, chipselect, write_n (active low),
// writedata, readdata (registered by the slave).
// Modports: master drives the request, slave returns readdata.
interface interval_timer_mc_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32
) ();

    logic [$clog2(NUM_CH)+1:0] address;
    logic                      chipselect;
    logic                      write_n;
    logic [DATA_W-1:0]         writedata;
    logic [DATA_W-1:0]         readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/interval_timer_mc_channel.sv
// rtl/interval_timer_mc_channel.sv - one interval timer channel
// Module timer_mc_channel: counter, period, control, status, snapshot,
// optional prescaler (TIMER_PRESCALE_EN) and interrupt for one channel.
// Ports: clk, reset (async, active high), wr_en (write to this channel),
// reg_sel (register offset), wdata, rdata (combinational read data for
// reg_sel), irq (TO & ITO).
module timer_mc_channel
    import timer_mc_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter int          DATA_W       = 32,
    parameter logic [31:0] RESET_PERIOD = 32'h00BEBC1F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [1:0]        reg_sel,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              irq
);

    localparam logic [CNT_W-1:0] RST_CNT  = CNT_W'(RESET_PERIOD);
    // zero_q starts consistent with the reset counter so no event is
    // manufactured out of reset.
    localparam logic             RST_ZERO = (RST_CNT == '0);

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] snapshot;
    logic [3:0]       ctl;
    logic             run;
    logic             to;
    logic             zero_q;
    logic             force_reload;

    logic wr_status, wr_control, wr_period, wr_snap;
    logic start_wr, stop_wr, at_zero, timeout, tick, count;
    logic unused_wdata;

`ifdef TIMER_PRESCALE_EN
    logic [PRE_W-1:0] prescale;
    logic [PRE_W-1:0] pre_cnt;
    assign tick = (pre_cnt == prescale);
`else
    assign tick = 1'b1;
`endif

    assign wr_status  = wr_en && (reg_sel == REG_STATUS);
    assign wr_control = wr_en && (reg_sel == REG_CONTROL);
    assign wr_period  = wr_en && (reg_sel == REG_PERIOD);
    assign wr_snap    = wr_en && (reg_sel == REG_SNAP);
    assign start_wr   = wr_control && wdata[CTL_START];
    assign stop_wr    = wr_control && wdata[CTL_STOP];
    assign at_zero    = (counter == '0);
    assign timeout    = at_zero && !zero_q;
    assign count      = run && tick;
    assign irq        = to && ctl[CTL_ITO];
    assign unused_wdata = &{1'b0, wdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter      <= RST_CNT;
            period       <= RST_CNT;
            snapshot     <= '0;
            ctl          <= '0;
            run          <= 1'b0;
            to           <= 1'b0;
            zero_q       <= RST_ZERO;
            force_reload <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            prescale     <= '0;
            pre_cnt      <= '0;
`endif
        end else begin
            zero_q       <= at_zero;
            force_reload <= wr_period;

            if (wr_period)  period   <= wdata[CNT_W-1:0];
            if (wr_snap)    snapshot <= counter;
            if (wr_control) ctl      <= wdata[3:0];

            // A timeout landing on the clearing write must not be lost.
            if (timeout)        to <= 1'b1;
            else if (wr_status) to <= 1'b0;

            if (force_reload)   counter <= period;
            else if (count)     counter <= at_zero ? period : counter - CNT_W'(1);

            // START beats every clearing condition, including force_reload.
            if (start_wr)
                run <= 1'b1;
            else if (force_reload || stop_wr || (count && at_zero && !ctl[CTL_CONT]))
                run <= 1'b0;

`ifdef TIMER_PRESCALE_EN
            if (wr_control) prescale <= wdata[PRE_LSB +: PRE_W];
            if (start_wr || force_reload || !run || tick)
                pre_cnt <= '0;
            else
                pre_cnt <= pre_cnt + PRE_W'(1);
`endif
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_STATUS: begin
                rdata[ST_TO]  = to;
                rdata[ST_RUN] = run;
            end
            REG_CONTROL: begin
                rdata[3:0] = ctl;
`ifdef TIMER_PRESCALE_EN
                rdata[PRE_LSB +: PRE_W] = prescale;
`else
                rdata[PRE_LSB +: PRE_W] = '0;
`endif
            end
            REG_PERIOD: rdata[CNT_W-1:0] = period;
            default:    rdata[CNT_W-1:0] = snapshot;
        endcase
    end

endmodule

// File: rtl/interval_timer_mc.sv
// rtl/interval_timer_mc.sv - multi-channel Avalon-MM interval timer top level
// Optional prescaler selected by macro TIMER_PRESCALE_EN.
// Ports: clk, reset (async, active high), bus (interval_timer_mc_if.slave:
// address {channel, reg}, chipselect, write_n, writedata, readdata),
// irq[NUM_CH] per-channel interrupt, irq_any OR of irq.
module interval_timer_mc
    import timer_mc_pkg::*;
#(
    parameter int          NUM_CH       = 2,
    parameter int          CNT_W        = 32,
    parameter int          DATA_W       = 32,
    parameter logic [31:0] RESET_PERIOD = 32'h00BEBC1F
) (
    input  logic                clk,
    input  logic                reset,
    interval_timer_mc_if.slave  bus,
    output logic [NUM_CH-1:0]   irq,
    output logic                irq_any
);

    localparam int AW   = $clog2(NUM_CH) + 2;
    localparam int CH_W = ch_bits(NUM_CH);

    logic [CH_W-1:0]   ch_idx;
    logic              wr_strobe;
    logic [DATA_W-1:0] ch_rdata [NUM_CH];
    logic [DATA_W-1:0] rd_mux;

    assign wr_strobe = bus.chipselect & ~bus.write_n;

    generate
        if (AW > 2) begin : g_ch_dec
            assign ch_idx = bus.address[AW-1:2];
        end else begin : g_one_ch
            assign ch_idx = '0;
        end
    endgenerate

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_mc_channel #(
            .CNT_W        (CNT_W),
            .DATA_W       (DATA_W),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_strobe && (ch_idx == CH_W'(i))),
            .reg_sel (bus.address[1:0]),
            .wdata   (bus.writedata),
            .rdata   (ch_rdata[i]),
            .irq     (irq[i])
        );
    end

    // Channel indices with no channel behind them match nothing and read 0.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == CH_W'(i)) rd_mux = ch_rdata[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.readdata <= '0;
        else       bus.readdata <= rd_mux;
    end

    assign irq_any = |irq;

endmodule
